// File: rtl/fifo_xfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_xfer_ctrl_if
// Groups the upstream-FIFO read port and the downstream-FIFO write port used by
// fifo_xfer_ctrl.
//   master : the transfer controller (drives src_rd, dst_wr, dst_din)
//   slave  : the FIFO side (drives src_empty, src_valid, src_dout,
//            dst_count, dst_full)
// Parameters:
//   DATA_W : word width
//   CW     : width of dst_count ($clog2(DST_DEPTH)+1)
// -----------------------------------------------------------------------------
interface fifo_xfer_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CW     = 10
);
    logic              src_rd;
    logic              src_empty;
    logic              src_valid;
    logic [DATA_W-1:0] src_dout;
    logic [CW-1:0]     dst_count;
    logic              dst_full;
    logic              dst_wr;
    logic [DATA_W-1:0] dst_din;

    modport master (
        output src_rd, dst_wr, dst_din,
        input  src_empty, src_valid, src_dout, dst_count, dst_full
    );

    modport slave (
        input  src_rd, dst_wr, dst_din,
        output src_empty, src_valid, src_dout, dst_count, dst_full
    );
endinterface

// File: rtl/fifo_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_xfer_ctrl
// Moves words from an upstream FIFO (read latency RD_LAT) into a downstream
// FIFO. Reads are throttled by an in-flight credit counter so the downstream
// FIFO cannot overflow whatever the read latency.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, xfer_len : burst start pulse and length (0 = unlimited)
//   stop            : level, ends the burst early
//   bus (master)    : upstream read / downstream write port
//   busy, done      : RUN/DRAIN indicator, one-cycle completion pulse
//   xfer_count      : words written in the current or last burst
//   err             : sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module fifo_xfer_ctrl #(
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int DST_DEPTH = 512,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     xfer_len,
    input  logic                 stop,
    fifo_xfer_ctrl_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     xfer_count,
    output logic                 err
);
    localparam int CW = $clog2(DST_DEPTH) + 1;
    localparam int OW = $clog2(RD_LAT + 2) + 1;
    localparam int FW = $clog2(RD_LAT + 1);
    localparam logic [CW:0]      DEPTH_CMP = (CW+1)'(DST_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [OW-1:0]    OUT_ZERO  = {OW{1'b0}};
    localparam logic [OW-1:0]    OUT_ONE   = OW'(1);
    localparam logic [FW-1:0]    FL_ZERO   = {FW{1'b0}};
    localparam logic [FW-1:0]    FL_ONE    = FW'(1);
    localparam logic [FW-1:0]    FL_LOAD   = FW'(RD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  xfer_len_r, issued_r, xfer_count_r;
    logic [OW-1:0]     outstanding_r;
    logic [FW-1:0]     flush_r;
    logic              dst_wr_r, busy_r, done_r, err_r;
    logic [DATA_W-1:0] dst_din_r;
    logic              src_rd_s, start_ok_s, len_ok_s, len_hit_s, credit_ok_s;
    logic              valid_live_s, busy_nxt_s, done_nxt_s, err_set_s;
    logic [CW:0]       credit_sum_s;

    // Words still in the upstream pipe at reset belong to the aborted burst;
    // flush_r masks src_valid for RD_LAT cycles after reset so they are dropped.
    assign valid_live_s = bus.src_valid && (flush_r == FL_ZERO);
    assign start_ok_s   = start && (state_r == ST_IDLE);
    assign len_ok_s     = (xfer_len_r == CNT_ZERO) || (issued_r < xfer_len_r);
    assign len_hit_s    = (xfer_len_r != CNT_ZERO) && (issued_r == xfer_len_r);
    // Occupancy plus words already requested must stay below capacity.
    assign credit_sum_s = {1'b0, bus.dst_count} + (CW+1)'(outstanding_r);
    assign credit_ok_s  = credit_sum_s < DEPTH_CMP;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (len_hit_s || stop) state_nxt_s = ST_DRAIN;
                else                   state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (outstanding_r == OUT_ZERO) state_nxt_s = ST_DONE;
                else                           state_nxt_s = ST_DRAIN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: read issue and next values of the registered status flags.
    always_comb begin
        src_rd_s   = 1'b0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        // stop overrides a read that would otherwise be issued this cycle.
        if ((state_r == ST_RUN) && !stop && !bus.src_empty && len_ok_s &&
            credit_ok_s && !reset) begin
            src_rd_s = 1'b1;
        end else begin
            src_rd_s = 1'b0;
        end
        case (state_nxt_s)
            ST_RUN:   busy_nxt_s = 1'b1;
            ST_DRAIN: busy_nxt_s = 1'b1;
            ST_DONE:  done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Burst bookkeeping: latched length, issued reads, written words, in-flight count.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_len_r    <= CNT_ZERO;
            issued_r      <= CNT_ZERO;
            xfer_count_r  <= CNT_ZERO;
            outstanding_r <= OUT_ZERO;
        end else if (start_ok_s) begin
            xfer_len_r    <= xfer_len;
            issued_r      <= CNT_ZERO;
            xfer_count_r  <= CNT_ZERO;
            outstanding_r <= OUT_ZERO;
        end else begin
            if (src_rd_s) issued_r <= issued_r + CNT_ONE;
            else          issued_r <= issued_r;
            if (dst_wr_r) xfer_count_r <= xfer_count_r + CNT_ONE;
            else          xfer_count_r <= xfer_count_r;
            case ({src_rd_s, dst_wr_r})
                2'b10: outstanding_r <= outstanding_r + OUT_ONE;
                // A stray write (already flagged as an error) must not underflow.
                2'b01: begin
                    if (outstanding_r != OUT_ZERO) outstanding_r <= outstanding_r - OUT_ONE;
                    else                           outstanding_r <= outstanding_r;
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Registered write stage and post-reset flush window.
    always_ff @(posedge clk) begin
        if (reset) begin
            dst_wr_r  <= 1'b0;
            dst_din_r <= {DATA_W{1'b0}};
            flush_r   <= FL_LOAD;
        end else begin
            dst_wr_r  <= valid_live_s;
            dst_din_r <= bus.src_dout;
            if (flush_r != FL_ZERO) flush_r <= flush_r - FL_ONE;
            else                    flush_r <= flush_r;
        end
    end

    assign err_set_s = (valid_live_s && (outstanding_r == OUT_ZERO) && !dst_wr_r) ||
                       (dst_wr_r && bus.dst_full) ||
                       (start && busy_r);

    // Registered status outputs and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            err_r  <= err_r | err_set_s;
        end
    end

    assign bus.src_rd  = src_rd_s;
    assign bus.dst_wr  = dst_wr_r;
    assign bus.dst_din = dst_din_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign xfer_count  = xfer_count_r;
    assign err         = err_r;
endmodule
